// File: rtl/cap_sense_scanner_pkg.sv
// cap_sense_scanner_pkg
//   Shared definitions for the capacitive pad scanner: scan FSM encoding,
//   default geometry, and the processor-visible I/O addresses.
//   No ports (package).
package cap_sense_scanner_pkg;

   localparam int NUM_PADS_DEF = 9;
   localparam int CNT_W_DEF    = 12;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DISCHARGE = 2'd1,
      CHARGE    = 2'd2,
      EVAL      = 2'd3
   } scan_state_t;

   // Memory-mapped I/O word addresses used by the processor skeleton.
   localparam logic [7:0] ADDR_TOUCH_STATE = 8'h40;  // read: debounced bitmap
   localparam logic [7:0] ADDR_EVENT_FLAGS = 8'h41;  // read: latched rise events
   localparam logic [7:0] ADDR_EVENT_ACK   = 8'h42;  // write: 1 clears event bit

endpackage

// File: rtl/cap_pad_channel.sv
// cap_pad_channel
//   One sensor pad: input synchronizer, charge-time capture, baseline,
//   touch compare and debounce.
// Ports:
//   clock, reset       clock and asynchronous active-low reset
//   sense_raw          raw pad pin, asynchronous to clock
//   charge_clr         high in DISCHARGE; re-arms the capture for next charge
//   charge_en          high in CHARGE
//   timeout            charge counter reached its limit this cycle
//   cnt                shared charge counter
//   eval_cal           EVAL cycle that captures the baseline
//   eval_cmp           EVAL cycle that evaluates touch
//   thresh             touch margin above baseline
//   done               pad has latched, or latches this cycle
//   touch              debounced touch state
//   rise               touch goes 0->1 on this clock edge
module cap_pad_channel #(
   parameter int CNT_W    = 12,
   parameter int DEBOUNCE = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sense_raw,
   input  logic             charge_clr,
   input  logic             charge_en,
   input  logic             timeout,
   input  logic [CNT_W-1:0] cnt,
   input  logic             eval_cal,
   input  logic             eval_cmp,
   input  logic [CNT_W-1:0] thresh,
   output logic             done,
   output logic             touch,
   output logic             rise
);

   localparam int AGR_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

   logic             sync_p0, sync_p1;
   logic             latched;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] baseline;
   logic [AGR_W-1:0] agree;
   logic [CNT_W:0]   limit;
   logic             raw_touch;
   logic             at_limit;

   // Extra bit keeps baseline + thresh from wrapping.
   assign limit     = {1'b0, baseline} + {1'b0, thresh};
   assign raw_touch = ({1'b0, count} > limit);
   assign at_limit  = (agree == AGR_W'(DEBOUNCE - 1));
   assign done      = latched | sync_p1;
   assign rise      = eval_cmp & raw_touch & ~touch & at_limit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_p0  <= 1'b0;
         sync_p1  <= 1'b0;
         latched  <= 1'b0;
         count    <= '0;
         baseline <= '0;
         agree    <= '0;
         touch    <= 1'b0;
      end else begin
         // --- stage p0 -> p1: metastability synchronizer ---
         sync_p0 <= sense_raw;
         sync_p1 <= sync_p0;

         // First high sample wins; a pad still low at timeout takes the
         // counter value, which equals the timeout limit on that cycle.
         if (charge_clr) begin
            latched <= 1'b0;
         end else if (charge_en && !latched && (sync_p1 || timeout)) begin
            latched <= 1'b1;
            count   <= cnt;
         end

         if (eval_cal)
            baseline <= count;

         if (eval_cmp) begin
            if (raw_touch != touch) begin
               if (at_limit) begin
                  touch <= ~touch;
                  agree <= '0;
               end else begin
                  agree <= agree + 1'b1;
               end
            end else begin
               agree <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/cap_sense_scanner.sv
// cap_sense_scanner
//   Drives the shared capacitive-sensor pin through discharge / charge /
//   evaluate scans, times each pad's charge, and produces a debounced touch
//   bitmap plus latched rising-edge touch events for the processor.
// Ports:
//   clock, reset   clock and asynchronous active-low reset
//   enable         scanning enable
//   thresh         touch margin added to each pad's baseline (EVAL only)
//   recal          one-cycle pulse; next completed scan re-captures baselines
//   sense_in       raw pad pins
//   sense_out      shared drive pin
//   touch_state    debounced touch bitmap
//   event_flags    latched rising-edge events, cleared by event_ack
//   event_ack      write-1-to-clear mask for event_flags
//   scan_done      one-cycle pulse during EVAL
//   calibrated     baselines are valid
module cap_sense_scanner
   import cap_sense_scanner_pkg::*;
#(
   parameter int NUM_PADS         = NUM_PADS_DEF,
   parameter int CNT_W            = CNT_W_DEF,
   parameter int TIMEOUT          = 2047,
   parameter int DISCHARGE_CYCLES = 500,
   parameter int DEBOUNCE         = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [CNT_W-1:0]    thresh,
   input  logic                recal,
   input  logic [NUM_PADS-1:0] sense_in,
   output logic                sense_out,
   output logic [NUM_PADS-1:0] touch_state,
   output logic [NUM_PADS-1:0] event_flags,
   input  logic [NUM_PADS-1:0] event_ack,
   output logic                scan_done,
   output logic                calibrated
);

   scan_state_t         state;
   logic [CNT_W-1:0]    cnt;   // discharge length, then charge time
   logic                recal_pend;
   logic [NUM_PADS-1:0] pad_done;
   logic [NUM_PADS-1:0] pad_rise;
   logic                in_discharge, in_charge, timeout_hit, all_done;
   logic                eval_cal, eval_cmp;

   assign in_discharge = (state == DISCHARGE);
   assign in_charge    = (state == CHARGE);
   assign timeout_hit  = in_charge && (cnt == CNT_W'(TIMEOUT));
   assign all_done     = &pad_done;
   assign eval_cal     = (state == EVAL) && (!calibrated || recal_pend);
   assign eval_cmp     = (state == EVAL) && calibrated && !recal_pend;

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
      cap_pad_channel #(
         .CNT_W    (CNT_W),
         .DEBOUNCE (DEBOUNCE)
      ) u_pad (
         .clock      (clock),
         .reset      (reset),
         .sense_raw  (sense_in[i]),
         .charge_clr (in_discharge),
         .charge_en  (in_charge),
         .timeout    (timeout_hit),
         .cnt        (cnt),
         .eval_cal   (eval_cal),
         .eval_cmp   (eval_cmp),
         .thresh     (thresh),
         .done       (pad_done[i]),
         .touch      (touch_state[i]),
         .rise       (pad_rise[i])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         sense_out   <= 1'b0;
         scan_done   <= 1'b0;
         calibrated  <= 1'b0;
         recal_pend  <= 1'b0;
         event_flags <= '0;
      end else begin
         scan_done   <= 1'b0;
         // A new rise beats a simultaneous acknowledge.
         event_flags <= (event_flags & ~event_ack) | pad_rise;

         // EVAL consumes any pending request; a pulse during EVAL itself
         // is kept for the following scan.
         if (state == EVAL)
            recal_pend <= recal;
         else if (recal)
            recal_pend <= 1'b1;

         if (eval_cal)
            calibrated <= 1'b1;

         case (state)
            IDLE: begin
               sense_out <= 1'b0;
               if (enable) begin
                  state <= DISCHARGE;
                  cnt   <= '0;
               end
            end
            DISCHARGE: begin
               if (!enable) begin
                  state     <= IDLE;
                  sense_out <= 1'b0;
               end else if (cnt == CNT_W'(DISCHARGE_CYCLES - 1)) begin
                  state     <= CHARGE;
                  cnt       <= '0;
                  sense_out <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CHARGE: begin
               if (!enable) begin
                  state     <= IDLE;
                  sense_out <= 1'b0;
               end else if (all_done || timeout_hit) begin
                  state     <= EVAL;
                  sense_out <= 1'b0;
                  scan_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EVAL: begin
               cnt   <= '0;
               state <= enable ? DISCHARGE : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cap_sense_scanner.sv
module tb_cap_sense_scanner;

   localparam int NP  = 9;
   localparam int CW  = 6;
   localparam int TMO = 63;
   localparam int DIS = 4;
   localparam int DEB = 2;
   localparam int THR = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [CW-1:0] thresh;
   logic          recal;
   logic [NP-1:0] sense_in;
   logic          sense_out;
   logic [NP-1:0] touch_state;
   logic [NP-1:0] event_flags;
   logic [NP-1:0] event_ack;
   logic          scan_done;
   logic          calibrated;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [NP-1:0] touch;
      logic [NP-1:0] flags;
      logic          cal;
      int            clen;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   logic          m_cal, m_recal;
   logic [NP-1:0] m_touch, m_flags;
   int            m_base  [NP];
   int            m_agree [NP];

   int kv [NP];

   cap_sense_scanner #(
      .NUM_PADS         (NP),
      .CNT_W            (CW),
      .TIMEOUT          (TMO),
      .DISCHARGE_CYCLES (DIS),
      .DEBOUNCE         (DEB)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .thresh      (thresh),
      .recal       (recal),
      .sense_in    (sense_in),
      .sense_out   (sense_out),
      .touch_state (touch_state),
      .event_flags (event_flags),
      .event_ack   (event_ack),
      .scan_done   (scan_done),
      .calibrated  (calibrated)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      m_cal = 1'b0; m_recal = 1'b0; m_touch = '0; m_flags = '0;
      for (int i = 0; i < NP; i++) begin
         m_base[i] = 0; m_agree[i] = 0;
      end
   endtask

   // k[i] = charge index at which pad i's raw input goes high, -1 = never.
   task automatic model_scan(input int k [NP], input logic [NP-1:0] ack);
      exp_t          e;
      int            cnt [NP];
      int            mx;
      bit            all;
      bit            raw;
      logic [NP-1:0] rise;
      mx = 0; all = 1'b1; rise = '0;
      for (int i = 0; i < NP; i++) begin
         if (k[i] < 0 || k[i] + 2 > TMO) begin
            cnt[i] = TMO; all = 1'b0;
         end else begin
            cnt[i] = k[i] + 2;
            if (k[i] > mx) mx = k[i];
         end
      end
      e.clen = all ? mx + 3 : TMO + 1;
      if (!m_cal || m_recal) begin
         for (int i = 0; i < NP; i++) m_base[i] = cnt[i];
         m_cal = 1'b1; m_recal = 1'b0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            raw = (cnt[i] > m_base[i] + THR);
            if (raw != m_touch[i]) begin
               m_agree[i]++;
               if (m_agree[i] == DEB) begin
                  m_touch[i] = raw; m_agree[i] = 0; rise[i] = raw;
               end
            end else begin
               m_agree[i] = 0;
            end
         end
      end
      m_flags = (m_flags & ~ack) | rise;
      e.touch = m_touch; e.flags = m_flags; e.cal = m_cal;
      sb.push_back(e);
   endtask

   // One full scan: push expectation, drive pads during CHARGE, compare at
   // the end of EVAL. ack is driven during the EVAL cycle.
   task automatic run_scan(input int k [NP], input logic [NP-1:0] ack);
      exp_t e;
      int   clen, w;
      model_scan(k, ack);
      w = 0;
      while (sense_out !== 1'b1 && w < 200) begin
         @(posedge clock); #1; w++;
      end
      total++;
      if (sense_out !== 1'b1) begin
         bad++; $display("FAIL charge_start: sense_out=%b after %0d cycles, required 1", sense_out, w);
      end
      clen = 0;
      while (sense_out === 1'b1 && clen < 100) begin
         for (int i = 0; i < NP; i++) sense_in[i] = (k[i] >= 0 && clen >= k[i]);
         @(posedge clock); #1; clen++;
      end
      sense_in = '0;
      total++;
      if (scan_done !== 1'b1) begin
         bad++; $display("FAIL scan_done_eval: got %b, required 1", scan_done);
      end
      event_ack = ack;
      @(posedge clock); #1;
      event_ack = '0;
      e = sb.pop_front();
      total++;
      if (clen !== e.clen) begin
         bad++; $display("FAIL charge_len: got %0d, required %0d", clen, e.clen);
      end
      total++;
      if (scan_done !== 1'b0) begin
         bad++; $display("FAIL scan_done_pulse: got %b, required 0", scan_done);
      end
      total++;
      if (touch_state !== e.touch) begin
         bad++; $display("FAIL touch_state: got %h, required %h", touch_state, e.touch);
      end
      total++;
      if (event_flags !== e.flags) begin
         bad++; $display("FAIL event_flags: got %h, required %h", event_flags, e.flags);
      end
      total++;
      if (calibrated !== e.cal) begin
         bad++; $display("FAIL calibrated: got %b, required %b", calibrated, e.cal);
      end
   endtask

   // Wait for CHARGE to start, then advance to charge index n (pads low).
   task automatic wait_charge(input int n);
      int w;
      w = 0;
      while (sense_out !== 1'b1 && w < 200) begin
         @(posedge clock); #1; w++;
      end
      total++;
      if (sense_out !== 1'b1) begin
         bad++; $display("FAIL wait_charge: sense_out=%b, required 1", sense_out);
      end
      repeat (n) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      total++;
      if ({sense_out, scan_done, calibrated} !== 3'b000 || touch_state !== '0 || event_flags !== '0) begin
         bad++;
         $display("FAIL %s: sense_out=%b scan_done=%b calibrated=%b touch=%h flags=%h, required all 0",
                  tag, sense_out, scan_done, calibrated, touch_state, event_flags);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; recal = 1'b0; event_ack = '0; sense_in = '0;
      thresh = 6'd5;
      model_reset();
      #2 reset = 1'b0;
      #10;
      check_zero_outputs("reset_state");
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1;
      total++;
      if (sense_out !== 1'b0) begin
         bad++; $display("FAIL idle_drive: sense_out=%b, required 0", sense_out);
      end
   endtask

   task automatic test_calibration();
      int w;
      enable = 1'b1;
      w = 0;
      while (sense_out !== 1'b1 && w < 50) begin
         @(posedge clock); #1; w++;
      end
      total++;
      if (w !== DIS + 1) begin
         bad++; $display("FAIL discharge_len: edges to charge %0d, required %0d", w, DIS + 1);
      end
      total++;
      if (calibrated !== 1'b0) begin
         bad++; $display("FAIL precal: calibrated=%b, required 0", calibrated);
      end
      kv = '{default: 8};
      run_scan(kv, '0);
   endtask

   task automatic test_touch_debounce();
      kv = '{default: 8}; kv[4] = 20;
      run_scan(kv, '0);
      total++;
      if (touch_state !== 9'h000) begin
         bad++; $display("FAIL single_scan_touch: got %h, required 000", touch_state);
      end
      run_scan(kv, '0);
      total++;
      if (touch_state !== 9'h010 || event_flags !== 9'h010) begin
         bad++; $display("FAIL debounced_touch: touch=%h flags=%h, required 010/010", touch_state, event_flags);
      end
   endtask

   task automatic test_timeout();
      kv = '{default: 8}; kv[4] = 20; kv[0] = -1;
      run_scan(kv, '0);
   endtask

   task automatic test_threshold_edge();
      // count 15 equals baseline+thresh (no touch); 16 exceeds it.
      kv = '{default: 8}; kv[4] = 20; kv[1] = 13; kv[2] = 14;
      run_scan(kv, '0);
      run_scan(kv, '0);
      total++;
      if (touch_state !== 9'h014) begin
         bad++; $display("FAIL threshold_edge: got %h, required 014", touch_state);
      end
   endtask

   task automatic test_ack_collision();
      event_ack = 9'h014;
      m_flags = m_flags & ~9'h014;
      @(posedge clock); #1;
      event_ack = '0;
      total++;
      if (event_flags !== 9'h000) begin
         bad++; $display("FAIL ack_clear: got %h, required 000", event_flags);
      end
      kv = '{default: 8};
      run_scan(kv, '0);
      run_scan(kv, '0);
      kv[4] = 20;
      run_scan(kv, '0);
      run_scan(kv, 9'h010);
      total++;
      if (event_flags !== 9'h010) begin
         bad++; $display("FAIL ack_set_collision: got %h, required 010", event_flags);
      end
   endtask

   task automatic test_disable();
      int w;
      int sd;
      kv = '{default: 8}; kv[4] = 20;
      wait_charge(3);
      enable = 1'b0;
      @(posedge clock); #1;
      total++;
      if (sense_out !== 1'b0 || scan_done !== 1'b0) begin
         bad++; $display("FAIL disable_idle: sense_out=%b scan_done=%b, required 0/0", sense_out, scan_done);
      end
      sd = 0;
      repeat (4) begin
         @(posedge clock); #1;
         if (scan_done !== 1'b0 || sense_out !== 1'b0) sd++;
      end
      total++;
      if (sd !== 0) begin
         bad++; $display("FAIL disable_quiet: %0d active cycles, required 0", sd);
      end
      total++;
      if (touch_state !== 9'h010) begin
         bad++; $display("FAIL disable_hold: touch=%h, required 010", touch_state);
      end
      enable = 1'b1;
      w = 0;
      while (sense_out !== 1'b1 && w < 50) begin
         @(posedge clock); #1; w++;
      end
      total++;
      if (w !== DIS + 1) begin
         bad++; $display("FAIL restart_discharge: edges to charge %0d, required %0d", w, DIS + 1);
      end
      run_scan(kv, '0);
   endtask

   task automatic test_async_reset();
      kv = '{default: 8}; kv[4] = 20;
      total++;
      if (touch_state !== 9'h010) begin
         bad++; $display("FAIL pre_reset_touch: got %h, required 010", touch_state);
      end
      wait_charge(5);
      #2 reset = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      model_reset();
      @(negedge clock) reset = 1'b1;
      run_scan(kv, '0);
   endtask

   task automatic test_recal();
      recal = 1'b1;
      @(posedge clock); #1;
      recal = 1'b0;
      m_recal = 1'b1;
      kv = '{default: 12};
      run_scan(kv, '0);
      kv[4] = 18;
      run_scan(kv, '0);
      run_scan(kv, '0);
      total++;
      if (touch_state !== 9'h010) begin
         bad++; $display("FAIL recal_touch: got %h, required 010", touch_state);
      end
   endtask

   initial begin
      test_reset();
      test_calibration();
      test_touch_debounce();
      test_timeout();
      test_threshold_edge();
      test_ack_collision();
      test_disable();
      test_async_reset();
      test_recal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cap_sense_scanner.md
Name: cap_sense_scanner

Overview:
- Sequences the shared capacitive-sensor drive pin and times the charge of the 9 whack-a-mole pads.
- Each scan runs discharge, then charge, then evaluate. It measures the per-pad rise time and compares it against a per-pad baseline captured at calibration.
- Results are debounced into a touch bitmap and latched hit events, which the processor reads through the skeleton's I/O mapping.
- Sits between the top-level capacitive_sensors_in/capacitive_sensors_out pins and the processor's memory-mapped I/O.

Parameters:
- NUM_PADS, 9, number of sensor pads.
- CNT_W, 12, width of the charge-time counter and baselines.
- TIMEOUT, 2047, maximum charge cycles; pads not yet high get count = TIMEOUT.
- DISCHARGE_CYCLES, 500, cycles the drive pin is held low before each charge phase.
- DEBOUNCE, 3, consecutive agreeing scans required to change a pad's touch state.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  scanning enable.
- thresh  input  CNT_W  touch margin added to the baseline.
- recal  input  1  one-cycle pulse; the next completed scan re-captures baselines.
- sense_in  input  NUM_PADS  raw pad pins (asynchronous to clock).
- sense_out  output  1  shared drive pin.
- touch_state  output  NUM_PADS  debounced touch bitmap.
- event_flags  output  NUM_PADS  latched rising-edge touch events.
- event_ack  input  NUM_PADS  write-1-to-clear mask for event_flags.
- scan_done  output  1  one-cycle pulse at the end of each evaluate.
- calibrated  output  1  baselines are valid.

Behaviour:
- Reset (async, reset=0) sets all outputs to 0: sense_out=0, touch_state=0, event_flags=0, scan_done=0, calibrated=0. All counts, baselines and debounce counters are cleared, and the FSM goes to IDLE.
- sense_in passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, DISCHARGE, CHARGE, EVAL.
- IDLE:
  - sense_out=0.
  - Moves to DISCHARGE on the cycle after enable=1 is sampled.
- DISCHARGE:
  - sense_out=0 for exactly DISCHARGE_CYCLES cycles, then CHARGE.
- CHARGE:
  - sense_out=1; the cycle counter is 0 on the first CHARGE cycle and increments by 1 each cycle.
  - A pad's count latches the counter value on the first cycle its synchronized input is 1. Later toggles are ignored.
  - Leaves for EVAL when every pad has latched, or on the cycle the counter equals TIMEOUT. Un-latched pads then take TIMEOUT.
  - Net effect: a raw pad first sampled high at CHARGE index k yields count k+2.
- EVAL (exactly 1 cycle):
  - sense_out=0 and scan_done=1.
  - If calibrated=0 or a recal is pending: baseline[i]=count[i], calibrated=1, no touch evaluation this scan, pending recal cleared.
  - Otherwise: raw_touch[i] = count[i] > baseline[i]+thresh. The sum is computed in CNT_W+1 bits, so there is no wrap.
  - Debounce per pad: if raw_touch[i] differs from touch_state[i], increment that pad's agree counter, else clear it. When the counter reaches DEBOUNCE, toggle touch_state[i] and clear the counter.
  - Next state is DISCHARGE if enable=1, else IDLE.
- touch_state and event_flags update on the clock edge ending EVAL.
- event_flags[i] is set when touch_state[i] goes 0→1. Update rule each cycle: event_flags <= (event_flags & ~event_ack) | new_rise. Set wins over a simultaneous ack.
- enable=0 sampled in DISCHARGE or CHARGE: go to IDLE next cycle with sense_out=0. The partial scan is discarded; touch_state, event_flags and baselines are held.
- recal pulse: latched as pending in any state, honoured at the next EVAL. A recal pulse arriving during EVAL applies to the following scan.
- Asserting reset mid-scan: immediate return to the reset values above, including calibrated=0.
- thresh is sampled only in EVAL.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, DISCHARGE=2'd1, CHARGE=2'd2, EVAL=2'd3).
  - NUM_PADS and CNT_W defaults.
  - I/O address constants the processor uses to read touch_state and event_flags and to write event_ack.
- One natural sub-module: cap_pad_channel, instantiated NUM_PADS times. It contains the per-pad synchronizer, latched count, baseline, compare and debounce counter.
- The top level holds the FSM, shared counters, drive pin and event latch.

Test Plan:
Bench parameters: DISCHARGE_CYCLES=4, TIMEOUT=63, CNT_W=6, DEBOUNCE=2, thresh=5.
1. Calibration:
   - Stimulus: enable=1; all pads' raw inputs go high at CHARGE index 8.
   - Required: sense_out low 4 cycles, then high; EVAL reached at CHARGE index 10; scan_done pulses; calibrated=1; all baselines=10; touch_state=0.
2. Touch with debounce:
   - Stimulus: after calibration, pad 4 rises at k=20 (count 22 > 15) on two consecutive scans.
   - Required: touch_state=9'h010 and event_flags=9'h010 only after the 2nd scan; a single such scan leaves touch_state=0.
3. Timeout:
   - Stimulus: pad 0 never rises.
   - Required: CHARGE ends when the counter reaches 63; count0=63; the other pads latch normally.
4. Ack vs set collision:
   - Stimulus: event_ack=9'h010 asserted in the same cycle pad 4 re-rises.
   - Required: event_flags[4] stays 1. An ack on a non-colliding cycle clears it to 0.
5. Disable mid-charge:
   - Stimulus: enable=0 at CHARGE index 3.
   - Required: next cycle IDLE, sense_out=0, no scan_done; touch_state unchanged; re-enable restarts with DISCHARGE.
6. Async reset mid-scan:
   - Stimulus: reset=0 during CHARGE with touch_state=9'h010.
   - Required: immediately sense_out=0, touch_state=0, event_flags=0, calibrated=0; after release, the first scan recalibrates.
